// File: rtl/if_id_pipe_reg_pkg.sv
// rtl/if_id_pipe_reg_pkg.sv - shared widths, bubble encoding, sideband indices and occupancy states for the IF/ID register
package if_id_pipe_reg_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned INST_W_DEF = 32;
    localparam int unsigned SIDE_W_DEF = 2;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    localparam int unsigned SIDE_PRED  = 0;
    localparam int unsigned SIDE_FAULT = 1;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_FULL  = 2'd1,
        OCC_SKID  = 2'd2
    } occ_e;

endpackage

// File: rtl/if_id_pipe_reg_skid_buf.sv
// rtl/if_id_pipe_reg_skid_buf.sv - pipe_skid_buf: generic valid/ready skid buffer with flush (skid entry only with IF_ID_SKID_EN)
module pipe_skid_buf
    import if_id_pipe_reg_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    occ_e         state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         accept;
    logic         consume;

`ifdef IF_ID_SKID_EN
    // Ready is a flop so upstream never sees a path from out_ready_i.
    logic ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= (state_d != OCC_SKID);
        end
    end

    assign in_ready_o = ready_q;
`else
    assign in_ready_o = (state_q == OCC_EMPTY) || out_ready_i;
`endif

    assign out_valid_o = (state_q != OCC_EMPTY);
    assign out_data_o  = main_q;
    assign accept      = in_valid_i && in_ready_o && !flush_i;
    assign consume     = out_valid_o && out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        state_d = OCC_FULL;
                        main_d  = in_data_i;
                    end
                end
                OCC_FULL: begin
                    if (accept && consume) begin
                        main_d = in_data_i;
                    end else if (accept) begin
                        state_d = OCC_SKID;
                        skid_d  = in_data_i;
                    end else if (consume) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_SKID: begin
                    if (consume) begin
                        state_d = OCC_FULL;
                        main_d  = skid_q;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
    end

    // main_q is left untouched on flush so the last PC stays visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OCC_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/if_id_pipe_reg.sv
// rtl/if_id_pipe_reg.sv - IF->ID pipeline register with valid/ready, flush and sideband; IF_ID_SKID_EN selects the 2-entry skid build
module if_id_pipe_reg
    import if_id_pipe_reg_pkg::*;
#(
    parameter int unsigned        ADDR_W   = ADDR_W_DEF,
    parameter int unsigned        INST_W   = INST_W_DEF,
    parameter int unsigned        SIDE_W   = SIDE_W_DEF,
    parameter logic [INST_W-1:0]  NOP_INST = INST_W'(NOP_INST_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    input  logic [SIDE_W-1:0] if_side,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic [SIDE_W-1:0] id_side
);

    localparam int unsigned PW = ADDR_W + INST_W + SIDE_W;

    logic [PW-1:0]     hold;
    logic [ADDR_W-1:0] hold_pc;
    logic [INST_W-1:0] hold_inst;
    logic [SIDE_W-1:0] hold_side;

    pipe_skid_buf #(
        .W (PW)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .in_valid_i  (if_valid),
        .in_ready_o  (if_ready),
        .in_data_i   ({if_pc, if_inst, if_side}),
        .out_valid_o (id_valid),
        .out_ready_i (id_ready),
        .out_data_o  (hold)
    );

    assign {hold_pc, hold_inst, hold_side} = hold;

    // Decode sees a bubble whenever nothing valid is held; the PC is not masked.
    assign id_pc   = hold_pc;
    assign id_inst = id_valid ? hold_inst : NOP_INST;
    assign id_side = id_valid ? hold_side : '0;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// tb/tb_if_id_pipe_reg.sv - directed scoreboard bench for if_id_pipe_reg (both IF_ID_SKID_EN builds)
module tb_if_id_pipe_reg;

`ifdef IF_ID_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [1:0]  if_side;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [1:0]  id_side;

    int n_pass  = 0;
    int n_total = 0;

    logic [65:0] sb_q[$];
    logic [31:0] pend[$];

    if_id_pipe_reg dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .if_valid (if_valid),
        .if_ready (if_ready),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .if_side  (if_side),
        .id_valid (id_valid),
        .id_ready (id_ready),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .id_side  (id_side)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: drive at the falling edge, score just before the rising edge, return at the next falling edge.
    task automatic cyc(input logic v, input logic [31:0] pc, input logic [1:0] sd,
                       input logic rdy, input logic fl, output logic acc, output logic rdy_now);
        logic        con;
        logic [65:0] exp_e;
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst_of(pc);
        if_side  = sd;
        id_ready = rdy;
        flush    = fl;
        #1;
        rdy_now = if_ready;
        #3;
        acc = if_valid && if_ready && !flush;
        con = id_valid && id_ready;
        if (fl) begin
            sb_q.delete();
        end else begin
            if (con) begin
                if (sb_q.size() != 0) exp_e = sb_q.pop_front();
                else exp_e = '1;
                check("sb_out", {id_pc, id_inst, id_side}, exp_e);
            end
            if (acc) sb_q.push_back({pc, inst_of(pc), sd});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic acc, rn;
        rst_n    = 1'b0;
        flush    = 1'b0;
        if_valid = 1'b0;
        if_pc    = '0;
        if_inst  = '0;
        if_side  = '0;
        id_ready = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_valid", 66'(id_valid), 66'(0));
        check("rst_inst",  66'(id_inst),  66'(NOP));
        check("rst_side",  66'(id_side),  66'(0));
        check("rst_pc",    66'(id_pc),    66'(0));
        rst_n = 1'b1;
        #1;
        check("rst_if_ready", 66'(if_ready), 66'(1));
        @(negedge clk);

        // streaming
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 32'h100 + 32'(4 * k), 2'(k), 1'b1, 1'b0, acc, rn);
            check("t2_accept", 66'(acc), 66'(1));
            check("t2_valid",  66'(id_valid), 66'(1));
            check("t2_pc",     66'(id_pc), 66'(32'h100 + 32'(4 * k)));
        end
        cyc(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, acc, rn);
        check("t2_empty_valid", 66'(id_valid), 66'(0));
        check("t2_empty_inst",  66'(id_inst),  66'(NOP));

        // stall with skid, fetch re-offers until accepted
        pend.push_back(32'h200);
        pend.push_back(32'h204);
        pend.push_back(32'h208);
        for (int k = 0; k < 12 && (pend.size() != 0 || sb_q.size() != 0); k++) begin
            if (pend.size() != 0) cyc(1'b1, pend[0], 2'b00, (k >= 3), 1'b0, acc, rn);
            else cyc(1'b0, 32'h0, 2'b00, (k >= 3), 1'b0, acc, rn);
            if (acc) void'(pend.pop_front());
            if (k < 3) begin
                check("t3_hold_pc",    66'(id_pc), 66'(32'h200));
                check("t3_hold_valid", 66'(id_valid), 66'(1));
                check("t3_if_ready",   66'(if_ready), 66'(SKID ? (k == 0) : 1'b0));
            end
            if (k == 2) check("t3_blocked", 66'(acc), 66'(0));
            if (k == 3) check("t3_ready_path", 66'(rn), 66'(!SKID));
        end
        check("t3_drained", 66'(pend.size() + sb_q.size()), 66'(0));

        // flush while stalled (skid full in the skid build), same-cycle offer discarded
        cyc(1'b1, 32'h280, 2'b00, 1'b0, 1'b0, acc, rn);
        cyc(1'b1, 32'h284, 2'b00, 1'b0, 1'b0, acc, rn);
        cyc(1'b1, 32'h300, 2'b01, 1'b0, 1'b1, acc, rn);
        check("t4_valid",    66'(id_valid), 66'(0));
        check("t4_inst",     66'(id_inst),  66'(NOP));
        check("t4_side",     66'(id_side),  66'(0));
        check("t4_pc_hold",  66'(id_pc),    66'(32'h280));
        check("t4_if_ready", 66'(if_ready), 66'(1));
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, acc, rn);
            check("t4_no_300", 66'(id_valid), 66'(0));
        end

        // sideband held under stall then cleared
        cyc(1'b1, 32'h400, 2'b10, 1'b0, 1'b0, acc, rn);
        check("t5_side", 66'(id_side), 66'(2'b10));
        for (int k = 0; k < 2; k++) begin
            cyc(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, acc, rn);
            check("t5_side_hold", 66'(id_side), 66'(2'b10));
            check("t5_pc_hold",   66'(id_pc),   66'(32'h400));
        end
        cyc(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, acc, rn);
        check("t5_clear_valid", 66'(id_valid), 66'(0));
        check("t5_clear_side",  66'(id_side),  66'(0));
        check("t5_clear_inst",  66'(id_inst),  66'(NOP));

        // asynchronous reset mid-stall
        cyc(1'b1, 32'h500, 2'b01, 1'b0, 1'b0, acc, rn);
        cyc(1'b1, 32'h504, 2'b11, 1'b0, 1'b0, acc, rn);
        #2;
        rst_n    = 1'b0;
        if_valid = 1'b0;
        #1;
        check("t1_async_valid", 66'(id_valid), 66'(0));
        check("t1_async_inst",  66'(id_inst),  66'(NOP));
        check("t1_async_side",  66'(id_side),  66'(0));
        check("t1_async_pc",    66'(id_pc),    66'(0));
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t1_if_ready", 66'(if_ready), 66'(1));
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            cyc(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, acc, rn);
            check("t1_none_survive", 66'(id_valid), 66'(0));
        end

        check("sb_empty", 66'(sb_q.size()), 66'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
Parametrised IF->ID pipeline register, successor to the plain clocked IF/ID latch. Adds a valid/ready handshake on both sides, synchronous flush with bubble insertion, and sideband fields (prediction, fetch fault). Sits between the fetch unit and the decoder. Back-pressure from decode (hazard stall) propagates upstream without data loss.

Parameters:
ADDR_W, 32, PC width
INST_W, 32, instruction width
SIDE_W, 2, sideband width (bit0 = predicted-taken, bit1 = fetch fault)
NOP_INST, 32'h00000013, bubble instruction (addi x0,x0,0) driven when empty or flushed

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
flush  in  1  synchronous kill of all held entries (branch redirect / exception)
if_valid  in  1  fetch presents an entry
if_ready  out  1  register can accept this cycle
if_pc  in  ADDR_W  fetch PC
if_inst  in  INST_W  fetched instruction
if_side  in  SIDE_W  fetch sideband
id_valid  out  1  decode entry valid
id_ready  in  1  decode accepts (low = stall)
id_pc  out  ADDR_W  held PC
id_inst  out  INST_W  held instruction, NOP_INST when !id_valid
id_side  out  SIDE_W  held sideband, 0 when !id_valid

Behaviour:
- Reset (rst_n=0, async): id_valid=0, id_pc=0, id_inst=NOP_INST, id_side=0, occupancy=0. if_ready=1 once rst_n deasserts.
- Accept when if_valid&&if_ready; consume when id_valid&&id_ready. Both may occur in the same cycle.
- Latency: an accepted entry appears on id_* on the next rising edge (1 cycle), provided the stage is empty or consumed that cycle.
- While id_valid&&!id_ready, id_pc/id_inst/id_side/id_valid are held stable.
- Entry order is strictly FIFO. No entry is dropped or duplicated except by flush.
- Occupancy FSM (skid build): EMPTY(0), FULL(1), SKID(2).
  - EMPTY: accept -> FULL.
  - FULL: accept && consume -> FULL (main reloads). Accept && !consume -> SKID (entry goes to skid reg). Consume && !accept -> EMPTY.
  - SKID: consume -> FULL (skid moves to main). No accept is possible.
- if_ready is registered and equals (occupancy != SKID). It has no combinational path from id_ready.
- flush has the highest priority. Next edge: occupancy=EMPTY, id_valid=0, id_inst=NOP_INST, id_side=0; id_pc holds its last value.
  - An entry offered during the flush cycle is discarded even if if_ready=1.
  - A consume in the same cycle still counts downstream. The bench treats it as a killed entry.
- Reset asserted mid-stall or mid-skid: all state clears immediately; no entry survives.
- Widths are passed through unmodified; no arithmetic on PC.

Optional Feature:
IF_ID_SKID_EN
- Defined: 2-entry skid behaviour as above; if_ready is registered.
- Undefined: single register only (EMPTY/FULL). if_ready = !id_valid || id_ready, a combinational path. Accept in FULL requires a consume in the same cycle.
- Flush, reset and output rules are identical in both builds.
- Tests 1, 2, 4 and 5 apply to both builds. Test 3's registered-if_ready check applies only with the macro defined.

Decomposition:
- Shared defines package holds ADDR_W/INST_W defaults, NOP_INST, sideband bit indices (SIDE_PRED, SIDE_FAULT) and the occupancy encodings.
- One natural sub-module, pipe_skid_buf: a generic payload-width valid/ready skid buffer with flush.
  - if_id_pipe_reg concatenates {pc, inst, side} into it.
  - if_id_pipe_reg then applies NOP/zero masking on the outputs.

Test Plan:
1. Reset: rst_n=0 mid-cycle -> id_valid=0, id_inst=32'h00000013, id_side=0 immediately, without waiting for a clock edge.
2. Streaming: id_ready=1, 4 back-to-back entries pc=0x100..0x10C -> same PCs appear on id_pc one cycle later, consecutively, with if_ready held at 1.
3. Stall with skid: hold id_ready=0 for 3 cycles while offering pc 0x200, 0x204, 0x208.
   - Expect 0x200 held on id_pc, 0x204 captured in skid, if_ready=0 from cycle 2, 0x208 not accepted.
   - Release id_ready -> order 0x200, 0x204, 0x208.
4. Flush in SKID state, with if_valid=1 pc=0x300 in the same cycle -> next cycle id_valid=0, id_inst=NOP, if_ready=1; 0x300 never appears.
5. Sideband: if_side=2'b10 (fault) at pc=0x400 under a stall -> id_side=2'b10 is held stable, then cleared to 0 once consumed and empty.
